// File: rtl/mkio_rxbuf_ctrl.sv
// mkio_rxbuf_ctrl - receive-buffer controller for one MKIO subaddress.
//
// Sequences the write port of the subaddress RAM from a single clock. The
// protocol decoder streams words in. A completed message is handed to the
// host through a ready/ack handshake. The host reads the RAM through a
// latency-1 path.
//
// Build option: define MKIO_PINGPONG_EN for two-bank ping-pong buffering.
// In that mode the decoder fills wr_bank while the host owns rd_bank, and a
// completed message can overrun an unacknowledged one. Without the macro a
// single bank is used. The bank bit is then always 0, and a new message is
// refused with rx_busy while the host still holds the previous one.
module mkio_rxbuf_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // decoder side
  input  logic                  msg_start,
  input  logic [ADDR_WIDTH-1:0] msg_wc,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  msg_abort,
  // host side
  input  logic                  host_rd_en,
  input  logic [ADDR_WIDTH-1:0] host_rd_addr,
  input  logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic                  host_rd_valid,
  output logic                  msg_ready,
  output logic [ADDR_WIDTH:0]   msg_len,
  // status
  output logic                  rx_active,
  output logic                  rx_busy,
  output logic                  rx_overrun,
  output logic                  rx_err,
  // RAM ports
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH:0]   ram_wraddress,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH:0]   ram_rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // Counters carry one extra bit so that a full bank (2**ADDR_WIDTH words)
  // is representable without wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_BANK = CW'(1) << ADDR_WIDTH;

`ifdef MKIO_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_COMMIT
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         word_cnt_q;
  logic [CW-1:0]         wc_target_q;
  logic                  msg_ready_q;
  logic [CW-1:0]         msg_len_q;
  logic                  rx_active_q;
  logic                  rx_busy_q;
  logic                  rx_overrun_q;
  logic                  rx_err_q;
  logic                  ram_wren_q;
  logic [CW-1:0]         ram_wraddr_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  rd_valid_q;
  logic                  rd_bank_q;
  logic                  wr_bank_q;

  logic [CW-1:0]         wc_target_d;
  logic [CW-1:0]         word_cnt_d;
  logic                  start_blocked;
  logic                  commit_ok;

  // Decode the requested length, the next word index and the accept rules.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    wc_target_d   = {1'b0, msg_wc};
    word_cnt_d    = word_cnt_q + CW'(1);
    // A single bank cannot accept a new message while the host holds one.
    start_blocked = ~PINGPONG & msg_ready_q;
    // Commit may take the buffer if it is free or released this very cycle.
    commit_ok     = ~msg_ready_q | host_ack;
    if (msg_wc == '0) begin
      wc_target_d = FULL_BANK;
    end
  end

  // Write FSM plus all registered outputs, buffer ownership and read valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Later
    // assignments in this block override earlier ones, and that override
    // is how a commit beats a same-cycle host_ack.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      wc_target_q  <= '0;
      msg_ready_q  <= 1'b0;
      msg_len_q    <= '0;
      rx_active_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_err_q     <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_wraddr_q <= '0;
      ram_data_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_bank_q    <= PINGPONG;
    end else begin
      // Status strobes and the write enable are single-cycle pulses.
      rx_busy_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_err_q     <= 1'b0;
      ram_wren_q   <= 1'b0;
      rd_valid_q   <= host_rd_en;

      // Host release. A commit further down in this cycle takes priority.
      if (host_ack) begin
        msg_ready_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (msg_start) begin
            if (start_blocked) begin
              rx_busy_q <= 1'b1;
            end else begin
              state_q     <= S_RECV;
              rx_active_q <= 1'b1;
              wc_target_q <= wc_target_d;
              word_cnt_q  <= '0;
            end
          end
        end

        S_RECV: begin
          if (msg_abort) begin
            // Decoder error: drop the message. Abort beats rx_valid.
            state_q     <= S_IDLE;
            rx_active_q <= 1'b0;
            rx_err_q    <= 1'b1;
          end else if (msg_start) begin
            // A new message starts before the old one completed.
            rx_err_q <= 1'b1;
            if (start_blocked) begin
              rx_busy_q   <= 1'b1;
              state_q     <= S_IDLE;
              rx_active_q <= 1'b0;
            end else begin
              wc_target_q <= wc_target_d;
              word_cnt_q  <= '0;
            end
          end else if (rx_valid) begin
            ram_wren_q   <= 1'b1;
            ram_wraddr_q <= {wr_bank_q, word_cnt_q[ADDR_WIDTH-1:0]};
            ram_data_q   <= rx_data;
            word_cnt_q   <= word_cnt_d;
            if (word_cnt_d == wc_target_q) begin
              state_q     <= S_COMMIT;
              rx_active_q <= 1'b0;
            end
          end
        end

        S_COMMIT: begin
          // The last word is written to RAM during this cycle, so the
          // message is handed over exactly when its data is in place.
          if (commit_ok) begin
            msg_ready_q <= 1'b1;
            msg_len_q   <= wc_target_q;
            if (PINGPONG) begin
              rd_bank_q <= wr_bank_q;
              wr_bank_q <= ~wr_bank_q;
            end
          end else begin
            // Host still owns the previous message; the new one is lost.
            rx_overrun_q <= PINGPONG;
          end
          state_q <= S_IDLE;
        end

        default: begin
          state_q     <= S_IDLE;
          rx_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign msg_ready     = msg_ready_q;
  assign msg_len       = msg_len_q;
  assign rx_active     = rx_active_q;
  assign rx_busy       = rx_busy_q;
  assign rx_overrun    = rx_overrun_q;
  assign rx_err        = rx_err_q;
  assign ram_wren      = ram_wren_q;
  assign ram_wraddress = ram_wraddr_q;
  assign ram_data      = ram_data_q;
  assign host_rd_valid = rd_valid_q;
  assign host_rd_data  = ram_q;
  assign ram_rdaddress = {rd_bank_q, host_rd_addr};

endmodule

// File: tb/tb_mkio_rxbuf_ctrl.sv
// tb_mkio_rxbuf_ctrl - self-checking bench for mkio_rxbuf_ctrl.
// Message-level reference model: ownership flag, length, bank numbers and
// the expected RAM image. Follows MKIO_PINGPONG_EN like the design.
module tb_mkio_rxbuf_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int WORDS = 1 << AW;

`ifdef MKIO_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          msg_start, rx_valid, msg_abort, host_rd_en, host_ack;
  logic [AW-1:0] msg_wc, host_rd_addr;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] host_rd_data, ram_data, ram_q;
  logic          host_rd_valid, msg_ready, rx_active, rx_busy, rx_overrun, rx_err, ram_wren;
  logic [AW:0]   msg_len, ram_wraddress, ram_rdaddress;

  mkio_rxbuf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_start    (msg_start),
    .msg_wc       (msg_wc),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .msg_abort    (msg_abort),
    .host_rd_en   (host_rd_en),
    .host_rd_addr (host_rd_addr),
    .host_ack     (host_ack),
    .host_rd_data (host_rd_data),
    .host_rd_valid(host_rd_valid),
    .msg_ready    (msg_ready),
    .msg_len      (msg_len),
    .rx_active    (rx_active),
    .rx_busy      (rx_busy),
    .rx_overrun   (rx_overrun),
    .rx_err       (rx_err),
    .ram_data     (ram_data),
    .ram_wraddress(ram_wraddress),
    .ram_wren     (ram_wren),
    .ram_rdaddress(ram_rdaddress),
    .ram_q        (ram_q)
  );

  always #5 clk = ~clk;

  // Subaddress RAM with registered read.
  // NOTE: RAM contents are never reset; only written locations are read.
  logic [DW-1:0] ram [2*WORDS];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_wraddress] <= ram_data;
    ram_q <= ram[ram_rdaddress];
  end

  // Reference model at message level.
  bit            m_ready;
  int            m_len;
  bit            m_rd_bank, m_wr_bank;
  logic [DW-1:0] m_mem [2][WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ready   = 1'b0;
    m_len     = 0;
    m_rd_bank = 1'b0;
    m_wr_bank = PP;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  msg_ready, 0);
    check({tag, "_len"},    msg_len, 0);
    check({tag, "_active"}, rx_active, 0);
    check({tag, "_busy"},   rx_busy, 0);
    check({tag, "_ovr"},    rx_overrun, 0);
    check({tag, "_err"},    rx_err, 0);
    check({tag, "_wren"},   ram_wren, 0);
    check({tag, "_waddr"},  ram_wraddress, 0);
    check({tag, "_wdata"},  ram_data, 0);
    check({tag, "_rvalid"}, host_rd_valid, 0);
    check({tag, "_raddr"},  ram_rdaddress, {1'b0, host_rd_addr});
  endtask

  // One host read: address is combinational, data and valid one cycle later.
  task automatic host_read(input int idx);
    host_rd_en   = 1'b1;
    host_rd_addr = idx[AW-1:0];
    #1;
    check("rd_addr", ram_rdaddress, {m_rd_bank, idx[AW-1:0]});
    tick();
    host_rd_en = 1'b0;
    check("rd_valid", host_rd_valid, 1);
    check("rd_data", host_rd_data, m_mem[m_rd_bank][idx]);
  endtask

  task automatic do_ack();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    m_ready  = 1'b0;
    check("ack_ready", msg_ready, 0);
  endtask

  // Send one message. abort_at / restart_at < 0 disable those events.
  // base != 0 gives words base+1, base+2, ...; otherwise words are random.
  task automatic send_msg(input int wc, input int abort_at, input int restart_at,
                          input bit ack_commit, input bit start_commit,
                          input logic [DW-1:0] base);
    int            n;
    int            i;
    bit            restarted;
    bit            exp_ovr;
    logic [DW-1:0] w;
    n = (wc == 0) ? WORDS : wc;
    msg_start = 1'b1;
    msg_wc    = wc[AW-1:0];
    tick();
    msg_start = 1'b0;
    if (!PP && m_ready) begin
      check("busy_pulse", rx_busy, 1);
      check("busy_active", rx_active, 0);
      for (int k = 0; k < n && k < 4; k++) begin
        rx_valid = 1'b1;
        rx_data  = DW'($urandom);
        tick();
        check("busy_nowr", ram_wren, 0);
      end
      rx_valid = 1'b0;
      check("busy_ready", msg_ready, 1);
      return;
    end
    check("start_active", rx_active, 1);
    check("start_busy", rx_busy, 0);
    i         = 0;
    restarted = 1'b0;
    while (i < n) begin
      if ($urandom_range(0, 5) == 0) begin
        rx_valid = 1'b0;
        tick();
        check("gap_nowr", ram_wren, 0);
        check("gap_active", rx_active, 1);
        continue;
      end
      w        = (base != '0) ? base + DW'(i + 1) : DW'($urandom);
      rx_valid = 1'b1;
      rx_data  = w;
      if (i == abort_at) begin
        msg_abort = 1'b1;
        tick();
        msg_abort = 1'b0;
        rx_valid  = 1'b0;
        check("abort_err", rx_err, 1);
        check("abort_nowr", ram_wren, 0);
        check("abort_active", rx_active, 0);
        check("abort_ready", msg_ready, m_ready);
        return;
      end
      if (i == restart_at && !restarted) begin
        restarted = 1'b1;
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        rx_valid  = 1'b0;
        check("restart_err", rx_err, 1);
        check("restart_nowr", ram_wren, 0);
        check("restart_active", rx_active, 1);
        i = 0;
        continue;
      end
      tick();
      check("wr_en", ram_wren, 1);
      check("wr_addr", ram_wraddress, {m_wr_bank, i[AW-1:0]});
      check("wr_data", ram_data, w);
      check("wr_err", rx_err, 0);
      m_mem[m_wr_bank][i] = w;
      i++;
    end
    rx_valid = 1'b0;
    // COMMIT cycle: ownership not yet changed.
    check("commit_hold", msg_ready, m_ready);
    check("commit_active", rx_active, 0);
    host_ack  = ack_commit;
    msg_start = start_commit;
    msg_wc    = AW'($urandom);
    tick();
    host_ack  = 1'b0;
    msg_start = 1'b0;
    if (!m_ready || ack_commit) begin
      m_ready = 1'b1;
      m_len   = n;
      exp_ovr = 1'b0;
      if (PP) begin
        m_rd_bank = m_wr_bank;
        m_wr_bank = ~m_wr_bank;
      end
    end else begin
      exp_ovr = 1'b1;
    end
    check("commit_ready", msg_ready, m_ready);
    check("commit_len", msg_len, m_len);
    check("commit_ovr", rx_overrun, exp_ovr);
    check("commit_ignore_start", rx_active, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (ram[k]) ram[k] = '0;
    rst_n = 1'b0; msg_start = 1'b0; msg_wc = '0; rx_valid = 1'b0; rx_data = '0;
    msg_abort = 1'b0; host_rd_en = 1'b0; host_rd_addr = '0; host_ack = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Basic receive with known words, then read back at latency 1.
    send_msg(3, -1, -1, 1'b0, 1'b0, 16'hA000);
    for (int k = 0; k < 3; k++) host_read(k);
    tick();
    check("rd_valid_drop", host_rd_valid, 0);

    // Full bank (wc = 0): 32 words, last index 31, length 32.
    do_ack();
    send_msg(0, -1, -1, 1'b0, 1'b0, '0);
    check("full_len", msg_len, WORDS);
    host_read(WORDS - 1);
    host_read(0);

    // Ignored inputs: ack while not ready, rx_valid while idle.
    do_ack();
    do_ack();
    rx_valid = 1'b1;
    rx_data  = 16'h5555;
    tick();
    rx_valid = 1'b0;
    check("idle_nowr", ram_wren, 0);
    check("idle_active", rx_active, 0);

    // Abort on word 2 of 5, then a one-word message.
    send_msg(5, 2, -1, 1'b0, 1'b0, '0);
    check("abort_not_ready", msg_ready, 0);
    send_msg(1, -1, -1, 1'b0, 1'b0, '0);
    host_read(0);

    // Held buffer: busy (single bank) or overrun (ping-pong), data intact.
    send_msg(4, -1, -1, 1'b0, 1'b0, '0);
    host_read(0);
    do_ack();
    send_msg(4, -1, -1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) host_read(k);
    // Ack in the COMMIT cycle.
    send_msg(2, -1, -1, 1'b1, 1'b0, '0);
    host_read(1);

    // Restart mid-message, and msg_start during COMMIT is ignored.
    do_ack();
    send_msg(4, -1, 2, 1'b0, 1'b1, '0);
    host_read(3);

    // Reset at word 3 of a message.
    do_ack();
    msg_start = 1'b1;
    msg_wc    = AW'(6);
    tick();
    msg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1;
      rx_data  = DW'($urandom);
      tick();
      check("pre_rst_addr", ram_wraddress, {m_wr_bank, k[AW-1:0]});
      m_mem[m_wr_bank][k] = rx_data;
    end
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    model_reset();
    check_reset_outputs("midrst");
    send_msg(1, -1, -1, 1'b0, 1'b0, '0);
    host_read(0);

    // Randomised message traffic.
    for (int it = 0; it < 80; it++) begin
      int wc;
      int n;
      wc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WORDS - 1))
                                       : int'($urandom_range(1, 6));
      n  = (wc == 0) ? WORDS : wc;
      case ($urandom_range(0, 5))
        0, 1: send_msg(wc, -1, -1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, '0);
        2:    send_msg(wc, $urandom_range(0, n - 1), -1, 1'b0, 1'b0, '0);
        3:    do_ack();
        4:    if (m_ready) host_read($urandom_range(0, m_len - 1));
              else       do_ack();
        default: send_msg(wc, -1, $urandom_range(0, n - 1), $urandom_range(0, 1) == 1, 1'b0, '0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
